// File: rtl/vtpg_pkg.sv
// Shared types and constants for the AXI4-Stream video test-pattern generator.
package vtpg_pkg;

   localparam int unsigned FRAME_CNT_W = 4;
   localparam int unsigned MODE_W      = 2;

   localparam logic [MODE_W-1:0] MODE_COUNTER = 2'd0;
   localparam logic [MODE_W-1:0] MODE_RAMP    = 2'd1;
   localparam logic [MODE_W-1:0] MODE_BARS    = 2'd2;
   localparam logic [MODE_W-1:0] MODE_CHECKER = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_FRAME_GAP = 2'd1,
      ST_SEND      = 2'd2,
      ST_LINE_GAP  = 2'd3
   } vtpg_state_e;

   // Counter width able to index 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vtpg_pixel_gen.sv
// Combinational pixel word for one beat, selected by pattern mode.
module vtpg_pixel_gen
   import vtpg_pkg::*;
#(
   parameter int unsigned DW     = 32,
   parameter int unsigned PPB    = 4,
   parameter int unsigned H      = 1280,
   parameter int unsigned BEAT_W = 9,
   parameter int unsigned LINE_W = 10
) (
   input  logic [MODE_W-1:0]      mode,
   input  logic [BEAT_W-1:0]      beat,
   input  logic [LINE_W-1:0]      line,
   input  logic [FRAME_CNT_W-1:0] frame_cnt,
   output logic [DW-1:0]          tdata_c
);

   localparam int unsigned PW = DW / PPB;

   logic [31:0]    ctr_word;
   logic [31:0]    line32;
   int unsigned    px_x;
   logic [PW-1:0]  pix;

   // Pixel k sits at bits [k*PW +: PW]; x is the absolute pixel column.
   always_comb begin
      tdata_c  = '0;
      px_x     = 0;
      pix      = '0;
      ctr_word = {4'(frame_cnt), 12'(line), 16'(beat)};
      line32   = 32'(line);
      for (int unsigned k = 0; k < PPB; k++) begin
         px_x = 32'(beat) * PPB + k;
         pix  = '0;
         case (mode)
            MODE_RAMP:    pix = PW'(px_x);
            MODE_BARS:    pix = PW'(((px_x * 8) / H) << (PW - 3));
            MODE_CHECKER: pix = (px_x[3] ^ line32[3]) ? '1 : '0;
            default:      pix = '0;
         endcase
         tdata_c[k*PW +: PW] = pix;
      end
      if (mode == MODE_COUNTER) tdata_c = DW'(ctr_word);
   end

endmodule

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream video test-pattern source: frame/line sequencing FSM and registered outputs.
// Optional VTPG_STALL_STATS_EN adds a per-frame backpressure cycle counter (stall_cnt).
module axis_video_pattern_gen
   import vtpg_pkg::*;
#(
   parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
   parameter int unsigned PIXELS_PER_BEAT      = 4,
   parameter int unsigned PIXELS_HORIZONTAL    = 1280,
   parameter int unsigned PIXELS_VERTICAL      = 1024,
   parameter int unsigned LINE_GAP             = 3,
   parameter int unsigned FRAME_GAP            = 1000
) (
   input  logic                                M_AXIS_ACLK,
   input  logic                                M_AXIS_ARESETN,
   input  logic                                enable,
   input  logic [MODE_W-1:0]                   mode,
   output logic                                M_AXIS_TVALID,
   output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
   output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
   output logic                                M_AXIS_TLAST,
   output logic                                M_AXIS_TUSER,
   input  logic                                M_AXIS_TREADY,
   output logic [FRAME_CNT_W-1:0]              frame_cnt,
`ifdef VTPG_STALL_STATS_EN
   output logic [31:0]                         stall_cnt,
`endif
   output logic                                frame_done
);

   localparam int unsigned DW      = C_M_AXIS_TDATA_WIDTH;
   localparam int unsigned PW      = DW / PIXELS_PER_BEAT;
   localparam int unsigned BPL     = PIXELS_HORIZONTAL / PIXELS_PER_BEAT;
   localparam int unsigned BEAT_W  = cnt_width(BPL);
   localparam int unsigned LINE_W  = cnt_width(PIXELS_VERTICAL);
   localparam int unsigned MAX_GAP = (FRAME_GAP > LINE_GAP) ? FRAME_GAP : LINE_GAP;
   localparam int unsigned GAP_W   = cnt_width(MAX_GAP + 1);

   if (PIXELS_HORIZONTAL % PIXELS_PER_BEAT != 0) begin : g_err_hdiv
      $error("PIXELS_HORIZONTAL must be a multiple of PIXELS_PER_BEAT");
   end
   if (PW < 3) begin : g_err_pw
      $error("pixel width must be at least 3 bits");
   end
   if (FRAME_GAP < 1) begin : g_err_fgap
      $error("FRAME_GAP must be at least 1");
   end

   vtpg_state_e             state_q, state_n;
   logic [BEAT_W-1:0]       beat_q, beat_n;
   logic [LINE_W-1:0]       line_q, line_n;
   logic [GAP_W-1:0]        gap_q, gap_n;
   logic [MODE_W-1:0]       mode_q, mode_n;
   logic [FRAME_CNT_W-1:0]  fcnt_n;
   logic                    done_n, tvalid_n, tlast_n, tuser_n;
   logic [DW-1:0]           tdata_n, pix_c;
   logic                    hs_c;

   assign hs_c         = M_AXIS_TVALID & M_AXIS_TREADY;
   assign M_AXIS_TSTRB = '1;

   // Pattern word for the beat that will be presented after this edge.
   vtpg_pixel_gen #(
      .DW     (DW),
      .PPB    (PIXELS_PER_BEAT),
      .H      (PIXELS_HORIZONTAL),
      .BEAT_W (BEAT_W),
      .LINE_W (LINE_W)
   ) u_pixel_gen (
      .mode      (mode_n),
      .beat      (beat_n),
      .line      (line_n),
      .frame_cnt (fcnt_n),
      .tdata_c   (pix_c)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_n = state_q;
      beat_n  = beat_q;
      line_n  = line_q;
      gap_n   = gap_q;
      mode_n  = mode_q;
      fcnt_n  = frame_cnt;
      done_n  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_n = ST_FRAME_GAP;
               gap_n   = '0;
               mode_n  = mode;
               beat_n  = '0;
               line_n  = '0;
            end
         end
         ST_FRAME_GAP: begin
            if (gap_q == GAP_W'(FRAME_GAP)) state_n = ST_SEND;
            else                            gap_n   = gap_q + 1'b1;
         end
         ST_SEND: begin
            if (hs_c) begin
               if (beat_q == BEAT_W'(BPL - 1)) begin
                  beat_n = '0;
                  gap_n  = '0;
                  if (line_q == LINE_W'(PIXELS_VERTICAL - 1)) begin
                     line_n  = '0;
                     fcnt_n  = frame_cnt + 1'b1;
                     done_n  = 1'b1;
                     mode_n  = mode;
                     state_n = enable ? ST_FRAME_GAP : ST_IDLE;
                  end else begin
                     line_n  = line_q + 1'b1;
                     state_n = (LINE_GAP > 0) ? ST_LINE_GAP : ST_SEND;
                  end
               end else begin
                  beat_n = beat_q + 1'b1;
               end
            end
         end
         ST_LINE_GAP: begin
            if (gap_q == GAP_W'(LINE_GAP - 1)) state_n = ST_SEND;
            else                               gap_n   = gap_q + 1'b1;
         end
         default: state_n = ST_IDLE;
      endcase
      tvalid_n = (state_n == ST_SEND);
      tlast_n  = tvalid_n && (beat_n == BEAT_W'(BPL - 1));
      tuser_n  = tvalid_n && (beat_n == '0) && (line_n == '0);
      tdata_n  = tvalid_n ? pix_c : '0;
   end

   always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
      if (!M_AXIS_ARESETN) begin
         state_q       <= ST_IDLE;
         beat_q        <= '0;
         line_q        <= '0;
         gap_q         <= '0;
         mode_q        <= '0;
         frame_cnt     <= '0;
         frame_done    <= 1'b0;
         M_AXIS_TVALID <= 1'b0;
         M_AXIS_TLAST  <= 1'b0;
         M_AXIS_TUSER  <= 1'b0;
         M_AXIS_TDATA  <= '0;
      end else begin
         state_q       <= state_n;
         beat_q        <= beat_n;
         line_q        <= line_n;
         gap_q         <= gap_n;
         mode_q        <= mode_n;
         frame_cnt     <= fcnt_n;
         frame_done    <= done_n;
         M_AXIS_TVALID <= tvalid_n;
         M_AXIS_TLAST  <= tlast_n;
         M_AXIS_TUSER  <= tuser_n;
         M_AXIS_TDATA  <= tdata_n;
      end
   end

`ifdef VTPG_STALL_STATS_EN
   logic frame_start_c;
   assign frame_start_c = (state_q == ST_FRAME_GAP) && (gap_q == GAP_W'(FRAME_GAP));

   // Backpressure cycles in the current frame; held through the following gap.
   always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
      if (!M_AXIS_ARESETN)                                         stall_cnt <= '0;
      else if (frame_start_c)                                      stall_cnt <= '0;
      else if (M_AXIS_TVALID && !M_AXIS_TREADY && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// Directed bench for axis_video_pattern_gen (16x3 frame, 4 px/beat, 32-bit TDATA).
module tb_axis_video_pattern_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [1:0]  mode;
   logic        tvalid, tlast, tuser, tready, frame_done;
   logic [31:0] tdata;
   logic [3:0]  tstrb;
   logic [3:0]  frame_cnt;
`ifdef VTPG_STALL_STATS_EN
   logic [31:0] stall_cnt;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int stab_err = 0;

   logic [31:0] cap_data[$];
   bit          cap_last[$];
   bit          cap_user[$];
   int          cap_cyc[$];

   always #5 clk = ~clk;

   axis_video_pattern_gen #(
      .C_M_AXIS_TDATA_WIDTH (32),
      .PIXELS_PER_BEAT      (4),
      .PIXELS_HORIZONTAL    (16),
      .PIXELS_VERTICAL      (3),
      .LINE_GAP             (2),
      .FRAME_GAP            (5)
   ) dut (
      .M_AXIS_ACLK    (clk),
      .M_AXIS_ARESETN (rst_n),
      .enable         (enable),
      .mode           (mode),
      .M_AXIS_TVALID  (tvalid),
      .M_AXIS_TDATA   (tdata),
      .M_AXIS_TSTRB   (tstrb),
      .M_AXIS_TLAST   (tlast),
      .M_AXIS_TUSER   (tuser),
      .M_AXIS_TREADY  (tready),
      .frame_cnt      (frame_cnt),
`ifdef VTPG_STALL_STATS_EN
      .stall_cnt      (stall_cnt),
`endif
      .frame_done     (frame_done)
   );

   function automatic logic [31:0] exp_ctr(input int f, input int l, input int b);
      return {4'(f), 12'(l), 16'(b)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset(input logic en, input logic [1:0] md);
      rst_n  = 1'b0;
      enable = 1'b0;
      tready = 1'b0;
      mode   = 2'd0;
      tick();
      tick();
      enable = en;
      mode   = md;
      rst_n  = 1'b1;
   endtask

   // Collect n handshaken beats; rmode 0 always ready, 1 toggling, 2 first 7 valid cycles stalled.
   task automatic capture(input int n, input int rmode);
      int got = 0;
      int budget = 0;
      int vcnt = 0;
      logic [31:0] pd = '0;
      logic pl = 1'b0;
      bit pstall = 1'b0;
      cap_data.delete(); cap_last.delete(); cap_user.delete(); cap_cyc.delete();
      while (got < n && budget < 3000) begin
         if (pstall && (tvalid !== 1'b1 || tdata !== pd || tlast !== pl)) stab_err++;
         case (rmode)
            1:       tready = ~tready;
            2:       tready = (vcnt >= 7);
            default: tready = 1'b1;
         endcase
         if (tvalid) vcnt++;
         if (tvalid && tready) begin
            cap_data.push_back(tdata);
            cap_last.push_back(tlast);
            cap_user.push_back(tuser);
            cap_cyc.push_back(cyc);
            got++;
         end
         pstall = tvalid && !tready;
         pd = tdata;
         pl = tlast;
         tick();
         budget++;
      end
      tready = 1'b0;
      if (got < n) begin
         n_checks++;
         $display("FAIL capture_timeout: got %0d beats, required %0d", got, n);
      end
   endtask

   task automatic wait_valid(output int first);
      first = -1;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (tvalid === 1'b1) begin
            first = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b1; mode = 2'd1; tready = 1'b1;
      tick();
      n_checks++; if (tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b want 0", tvalid); else n_pass++;
      n_checks++; if (tdata !== 32'h0) $display("FAIL rst_tdata: got %h want 0", tdata); else n_pass++;
      n_checks++; if (tlast !== 1'b0 || tuser !== 1'b0) $display("FAIL rst_tlast_tuser: got %b%b want 00", tlast, tuser); else n_pass++;
      n_checks++; if (frame_cnt !== 4'd0 || frame_done !== 1'b0) $display("FAIL rst_frame: got %h/%b want 0/0", frame_cnt, frame_done); else n_pass++;
      n_checks++; if (tstrb !== 4'hF) $display("FAIL tstrb: got %h want f", tstrb); else n_pass++;
   endtask

   task automatic test_basic();
      int first;
      int derr = 0, lerr = 0, uerr = 0;
      do_reset(1'b1, 2'd0);
      wait_valid(first);
      n_checks++; if (first != 6) $display("FAIL first_valid_cycle: got %0d want 6", first); else n_pass++;
      n_checks++; if (tdata !== 32'h0 || tuser !== 1'b1) $display("FAIL first_beat: got %h tuser %b want 00000000 tuser 1", tdata, tuser); else n_pass++;
      capture(12, 0);
      for (int i = 0; i < cap_data.size(); i++) begin
         if (cap_data[i] !== exp_ctr(0, i / 4, i % 4)) derr++;
         if (cap_last[i] != ((i % 4) == 3)) lerr++;
         if (cap_user[i] != (i == 0)) uerr++;
      end
      n_checks++; if (derr != 0) $display("FAIL basic_tdata: got %0d bad beats want 0", derr); else n_pass++;
      n_checks++; if (lerr != 0) $display("FAIL basic_tlast: got %0d bad beats want 0", lerr); else n_pass++;
      n_checks++; if (uerr != 0) $display("FAIL basic_tuser: got %0d bad beats want 0", uerr); else n_pass++;
      if (cap_cyc.size() == 12) begin
         n_checks++; if (cap_cyc[4] - cap_cyc[3] != 3) $display("FAIL line_gap: got %0d cycles between beats want 3", cap_cyc[4] - cap_cyc[3]); else n_pass++;
         n_checks++; if (cap_cyc[1] - cap_cyc[0] != 1) $display("FAIL beat_spacing: got %0d want 1", cap_cyc[1] - cap_cyc[0]); else n_pass++;
      end
      n_checks++; if (frame_done !== 1'b1 || frame_cnt !== 4'd1) $display("FAIL frame_done_pulse: got %b cnt %0d want 1 cnt 1", frame_done, frame_cnt); else n_pass++;
      tick();
      n_checks++; if (frame_done !== 1'b0) $display("FAIL frame_done_single: got %b want 0", frame_done); else n_pass++;
      capture(1, 0);
      n_checks++; if (cap_data.size() != 1 || cap_data[0] !== 32'h1000_0000 || cap_user[0] != 1'b1) $display("FAIL next_frame_first: got %h want 10000000 with tuser", (cap_data.size() != 0) ? cap_data[0] : 32'hx); else n_pass++;
   endtask

   task automatic test_backpressure();
      int derr = 0;
      stab_err = 0;
      do_reset(1'b1, 2'd0);
      capture(12, 1);
      for (int i = 0; i < cap_data.size(); i++)
         if (cap_data[i] !== exp_ctr(0, i / 4, i % 4) || cap_last[i] != ((i % 4) == 3)) derr++;
      n_checks++; if (derr != 0 || cap_data.size() != 12) $display("FAIL bp_sequence: got %0d bad of %0d want 0 of 12", derr, cap_data.size()); else n_pass++;
      n_checks++; if (stab_err != 0) $display("FAIL bp_stable: got %0d changes while stalled want 0", stab_err); else n_pass++;
      n_checks++; if (frame_cnt !== 4'd1) $display("FAIL bp_frame_cnt: got %0d want 1", frame_cnt); else n_pass++;
   endtask

   task automatic test_modes();
      do_reset(1'b1, 2'd1);
      capture(2, 0);
      n_checks++; if (cap_data[0] !== 32'h0302_0100) $display("FAIL ramp_beat0: got %h want 03020100", cap_data[0]); else n_pass++;
      n_checks++; if (cap_data[1] !== 32'h0706_0504) $display("FAIL ramp_beat1: got %h want 07060504", cap_data[1]); else n_pass++;
      mode = 2'd2;
      capture(10, 0);
      n_checks++; if (cap_data[9] !== 32'h0F0E_0D0C) $display("FAIL mode_held: got %h want 0f0e0d0c", cap_data[9]); else n_pass++;
      capture(2, 0);
      n_checks++; if (cap_data[0] !== 32'h2020_0000) $display("FAIL bars_beat0: got %h want 20200000", cap_data[0]); else n_pass++;
      n_checks++; if (cap_data[1] !== 32'h6060_4040) $display("FAIL bars_beat1: got %h want 60604040", cap_data[1]); else n_pass++;
      mode = 2'd3;
      capture(10, 0);
      capture(3, 0);
      n_checks++; if (cap_data[1] !== 32'h0000_0000) $display("FAIL checker_beat1: got %h want 00000000", cap_data[1]); else n_pass++;
      n_checks++; if (cap_data[2] !== 32'hFFFF_FFFF) $display("FAIL checker_beat2: got %h want ffffffff", cap_data[2]); else n_pass++;
   endtask

   task automatic test_enable_drop();
      int hi = 0;
      do_reset(1'b1, 2'd0);
      capture(6, 0);
      enable = 1'b0;
      capture(6, 0);
      n_checks++; if (cap_data[5] !== exp_ctr(0, 2, 3) || cap_last[5] != 1'b1) $display("FAIL drop_last_beat: got %h tlast %b want 00020003 tlast 1", cap_data[5], cap_last[5]); else n_pass++;
      tready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (tvalid !== 1'b0) hi++;
      end
      tready = 1'b0;
      n_checks++; if (hi != 0) $display("FAIL drop_idle: got %0d valid cycles want 0", hi); else n_pass++;
      n_checks++; if (frame_cnt !== 4'd1) $display("FAIL drop_frame_cnt: got %0d want 1", frame_cnt); else n_pass++;
   endtask

   task automatic test_reset_midframe();
      int first;
      do_reset(1'b1, 2'd0);
      capture(5, 0);
      n_checks++; if (tvalid !== 1'b1 || tdata !== exp_ctr(0, 1, 1)) $display("FAIL mid_beat: got v%b %h want v1 00010001", tvalid, tdata); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++; if (tvalid !== 1'b0 || tdata !== 32'h0 || tlast !== 1'b0 || tuser !== 1'b0) $display("FAIL async_reset: got v%b %h l%b u%b want all 0", tvalid, tdata, tlast, tuser); else n_pass++;
      tick();
      rst_n = 1'b1;
      wait_valid(first);
      n_checks++; if (first != 6 || tdata !== 32'h0 || tuser !== 1'b1) $display("FAIL restart: got cycle %0d %h tuser %b want 6 00000000 tuser 1", first, tdata, tuser); else n_pass++;
      n_checks++; if (frame_cnt !== 4'd0) $display("FAIL restart_frame_cnt: got %0d want 0", frame_cnt); else n_pass++;
   endtask

`ifdef VTPG_STALL_STATS_EN
   task automatic test_stall_stats();
      int first;
      do_reset(1'b1, 2'd0);
      capture(12, 2);
      n_checks++; if (stall_cnt !== 32'd7) $display("FAIL stall_frame_end: got %0d want 7", stall_cnt); else n_pass++;
      wait_valid(first);
      n_checks++; if (first < 0 || stall_cnt !== 32'd0) $display("FAIL stall_cleared: got %0d want 0", stall_cnt); else n_pass++;
   endtask
`endif

   initial begin
      rst_n = 1'b0; enable = 1'b0; mode = 2'd0; tready = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_modes();
      test_enable_drop();
      test_reset_midframe();
`ifdef VTPG_STALL_STATS_EN
      test_stall_stats();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
